// File: rtl/instruction_encoder_loader_pkg.sv
// Shared RV32I ALU encoding constants and loader FSM states, common to the
// instruction encoder/loader and the instruction decoder.
package instruction_encoder_loader_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } load_state_t;

  // Shift ops carry funct7 in the upper immediate bits of I-type words
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/riscv_field_encoder.sv
// Combinational encoder: decoded ALU operation fields -> 32-bit RV32I word,
// flagging codes that have no legal encoding.
module riscv_field_encoder
  import instruction_encoder_loader_pkg::*;
(
  input  logic        rtype,
  input  logic [3:0]  aluoper,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic        illegal_s;
  logic [31:0] word_s;

  // Map the ALU op to funct3/funct7 and assemble the R- or I-type word
  always_comb begin
    f3_s      = F3_ADD_SUB;
    f7_s      = F7_BASE;
    illegal_s = 1'b0;
    case (aluoper)
      ALU_ADD:  f3_s = F3_ADD_SUB;
      ALU_SUB: begin
        f3_s      = F3_ADD_SUB;
        f7_s      = F7_ALT;
        illegal_s = ~rtype;
      end
      ALU_XOR:  f3_s = F3_XOR;
      ALU_OR:   f3_s = F3_OR;
      ALU_AND:  f3_s = F3_AND;
      ALU_SLL:  f3_s = F3_SLL;
      ALU_SRL:  f3_s = F3_SRL_SRA;
      ALU_SRA: begin
        f3_s = F3_SRL_SRA;
        f7_s = F7_ALT;
      end
      ALU_SLT:  f3_s = F3_SLT;
      ALU_SLTU: f3_s = F3_SLTU;
      default:  illegal_s = 1'b1;
    endcase

    if (rtype) begin
      word_s = {f7_s, rs2, rs1, f3_s, rd, OP_R};
    end else if (is_shift(aluoper)) begin
      word_s = {f7_s, imm[4:0], rs1, f3_s, rd, OP_I};
    end else begin
      word_s = {imm, rs1, f3_s, rd, OP_I};
    end
  end

  assign word    = word_s;
  assign illegal = illegal_s;

endmodule

// File: rtl/instruction_encoder_loader.sv
// Streams encoded RV32I words into instruction memory from address 0 while
// holding the CPU busy; stops on the last operation or when memory is full.
module instruction_encoder_loader
  import instruction_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              in_rtype,
  input  logic [3:0]        in_aluoper,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  load_state_t       state_r, state_nx_s;
  logic              pend_r, pend_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s;
  logic [31:0]       wdata_r, wdata_nx_s;
  logic [ADDR_W:0]   count_r, count_nx_s;
  logic              error_r, error_nx_s;
  logic              last_seen_r, last_seen_nx_s;
  logic              ready_r, ready_nx_s;
  logic              busy_r, done_r;
  logic [ADDR_W+1:0] occ_nx_s;
  logic [31:0]       enc_word_s;
  logic              enc_illegal_s;
  logic              accept_s;

  riscv_field_encoder u_enc (
    .rtype   (in_rtype),
    .aluoper (in_aluoper),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (enc_word_s),
    .illegal (enc_illegal_s)
  );

  assign accept_s = in_valid && ready_r;

  // Next-state, pending write slot and counters; a queued write lands at count+pending
  always_comb begin
    state_nx_s     = state_r;
    pend_nx_s      = 1'b0;
    addr_nx_s      = addr_r;
    wdata_nx_s     = wdata_r;
    count_nx_s     = count_r + {{ADDR_W{1'b0}}, pend_r};
    error_nx_s     = error_r;
    last_seen_nx_s = last_seen_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx_s     = ST_LOAD;
          count_nx_s     = {(ADDR_W+1){1'b0}};
          error_nx_s     = 1'b0;
          last_seen_nx_s = 1'b0;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_LOAD: begin
        if (pend_r && (last_seen_r || (count_nx_s == DEPTH_C))) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_LOAD;
        end
        if (accept_s) begin
          last_seen_nx_s = in_last;
          if (enc_illegal_s) begin
            error_nx_s = 1'b1;
            state_nx_s = in_last ? ST_DONE : state_nx_s;
          end else begin
            pend_nx_s  = 1'b1;
            addr_nx_s  = count_nx_s[ADDR_W-1:0];
            wdata_nx_s = enc_word_s;
          end
        end else begin
          last_seen_nx_s = last_seen_r;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase

    occ_nx_s   = {1'b0, count_nx_s} + {{(ADDR_W+1){1'b0}}, pend_nx_s};
    ready_nx_s = (state_nx_s == ST_LOAD) && !last_seen_nx_s && (occ_nx_s < {1'b0, DEPTH_C});
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pend_r      <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= 32'h0000_0000;
      count_r     <= {(ADDR_W+1){1'b0}};
      error_r     <= 1'b0;
      last_seen_r <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pend_r      <= pend_nx_s;
      addr_r      <= addr_nx_s;
      wdata_r     <= wdata_nx_s;
      count_r     <= count_nx_s;
      error_r     <= error_nx_s;
      last_seen_r <= last_seen_nx_s;
      ready_r     <= ready_nx_s;
      busy_r      <= (state_nx_s == ST_LOAD);
      done_r      <= (state_nx_s == ST_DONE);
    end
  end

  assign in_ready  = ready_r;
  assign mem_we    = pend_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign count     = count_r;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Scoreboard bench for instruction_encoder_loader: random and directed programs
// checked against an arithmetic RV32I encoding model.
module tb_instruction_encoder_loader;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, in_rtype;
  logic [3:0]  in_aluoper;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        in_ready, mem_we, busy, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        f_start, f_valid, f_last;
  logic        f_ready, f_we, f_busy, f_done, f_error;
  logic [1:0]  f_addr;
  logic [31:0] f_wdata;
  logic [2:0]  f_count;

  int tests = 0;
  int fails = 0;
  int model_cnt = 0;
  bit model_err = 1'b0;
  int fwrites = 0;
  logic [39:0] exp_q[$];
  logic [33:0] fq[$];

  int f3_tab[10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
  int f7_tab[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};

  always #5 clock = ~clock;

  instruction_encoder_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_rtype(in_rtype), .in_aluoper(in_aluoper), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error), .count(count)
  );

  instruction_encoder_loader #(.ADDR_W(2), .DEPTH(4)) u_full (
    .clock(clock), .reset(reset), .start(f_start), .in_valid(f_valid), .in_ready(f_ready),
    .in_last(f_last), .in_rtype(in_rtype), .in_aluoper(in_aluoper), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(f_we), .mem_addr(f_addr),
    .mem_wdata(f_wdata), .busy(f_busy), .done(f_done), .error(f_error), .count(f_count)
  );

  // Reference encoding: fields weighted by their bit positions; returns 1 if illegal
  function automatic bit ref_encode(input bit rt, input int op, input int rd, input int rs1,
                                    input int rs2, input int imm, output logic [31:0] w);
    longint v;
    int immf;
    w = 32'h0;
    if (op > 9 || (op == 1 && !rt)) return 1'b1;
    if (rt) begin
      v = longint'(f7_tab[op]) * 33554432 + longint'(rs2) * 1048576;
    end else begin
      immf = (op >= 5 && op <= 7) ? f7_tab[op] * 32 + imm % 32 : imm;
      v = longint'(immf) * 1048576;
    end
    v = v + longint'(rs1) * 32768 + longint'(f3_tab[op]) * 4096 + longint'(rd) * 128 + (rt ? 51 : 19);
    w = v[31:0];
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bad(input string msg);
    tests++;
    fails++;
    $display("FAIL %s", msg);
  endtask

  // Scoreboard monitor for the main instance
  always @(negedge clock) begin
    logic [39:0] e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        bad($sformatf("unexpected write: addr 0x%02h data 0x%08h, expected no write", mem_addr, mem_wdata));
      end else begin
        e = exp_q.pop_front();
        check("write addr", 32'(mem_addr), 32'(e[39:32]));
        check("write data", mem_wdata, e[31:0]);
      end
    end
  end

  // Scoreboard monitor for the DEPTH=4 instance
  always @(negedge clock) begin
    logic [33:0] e;
    if (f_we) begin
      fwrites++;
      if (fq.size() == 0) begin
        bad($sformatf("full: unexpected write addr %0d, expected no write", f_addr));
      end else begin
        e = fq.pop_front();
        check("full write addr", 32'(f_addr), 32'(e[33:32]));
        check("full write data", f_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input bit rt, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm, input bit last,
                      input bit use_w, input logic [31:0] w);
    logic [31:0] mw;
    bit ill;
    int n;
    @(negedge clock);
    in_rtype = rt; in_aluoper = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      bad("accept timeout: in_ready=0 after 40 cycles, expected 1");
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    ill = ref_encode(rt, int'(op), int'(rd), int'(rs1), int'(rs2), int'(imm), mw);
    if (use_w) mw = w;
    if (ill) begin
      model_err = 1'b1;
    end else begin
      exp_q.push_back({model_cnt[7:0], mw});
      model_cnt++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_rand(input bit last);
    bit rt;
    rt = 1'($urandom_range(0, 1));
    send(rt, 4'($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
         last, 1'b0, 32'h0);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    model_cnt = 0;
    model_err = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("busy after start", 32'(busy), 32'd1);
  endtask

  task automatic finish_load(input string name);
    int n;
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!done) bad($sformatf("%s: done=0 after 40 cycles, expected 1", name));
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " in_ready"}, 32'(in_ready), 32'd0);
    check({name, " count"}, 32'(count), 32'(model_cnt));
    check({name, " error"}, 32'(error), 32'(model_err));
    check({name, " drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit need_new;
    logic [31:0] w;
    bit ill;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_rtype = 1'b0;
    in_aluoper = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 12'd0;
    f_start = 1'b0; f_valid = 1'b0; f_last = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset count", 32'(count), 32'd0);
    reset = 1'b0;

    // add x3,x1,x2 then sra x6,x7,x8 (last)
    do_start();
    send(1'b1, 4'b0000, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, 1'b1, 32'h002081B3);
    repeat (2) @(negedge clock);
    check("count after add", 32'(count), 32'd1);
    send(1'b1, 4'b0111, 5'd6, 5'd7, 5'd8, 12'd0, 1'b1, 1'b1, 32'h4083D333);
    finish_load("add/sra");

    // addi x5,x0,127 then srai x1,x2,3 (last)
    do_start();
    send(1'b0, 4'b0000, 5'd5, 5'd0, 5'd0, 12'd127, 1'b0, 1'b1, 32'h07F00293);
    send(1'b0, 4'b0111, 5'd1, 5'd2, 5'd0, 12'd3, 1'b1, 1'b1, 32'h40315093);
    finish_load("addi/srai");
    check("addi/srai done", 32'(done), 32'd1);

    // illegal I-type sub between two legal ops
    do_start();
    send(1'b1, 4'b0000, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, 1'b0, 32'h0);
    send(1'b0, 4'b0001, 5'd4, 5'd4, 5'd4, 12'd9, 1'b0, 1'b0, 32'h0);
    send(1'b0, 4'b0010, 5'd9, 5'd8, 5'd0, 12'hABC, 1'b1, 1'b0, 32'h0);
    finish_load("illegal");

    // illegal op as the final operation still terminates
    do_start();
    send(1'b1, 4'b0100, 5'd1, 5'd2, 5'd3, 12'd0, 1'b0, 1'b0, 32'h0);
    send(1'b1, 4'b1100, 5'd1, 5'd2, 5'd3, 12'd0, 1'b1, 1'b0, 32'h0);
    finish_load("illegal last");

    // random programs
    for (int l = 0; l < 6; l++) begin
      int n;
      do_start();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) send_rand(i == n - 1);
      finish_load("random");
    end

    // DEPTH=4 instance: six back-to-back ops offered, no last
    @(negedge clock);
    f_start = 1'b1;
    @(negedge clock);
    f_start = 1'b0;
    acc = 0;
    need_new = 1'b1;
    for (int c = 0; c < 40 && !f_done; c++) begin
      if (need_new && acc < 6) begin
        in_rtype = 1'($urandom_range(0, 1));
        in_aluoper = 4'($urandom_range(0, 9));
        if (in_aluoper == 4'd1 && !in_rtype) in_aluoper = 4'd0;
        in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_imm = 12'($urandom);
      end
      f_valid = (acc < 6);
      if (f_valid && f_ready) begin
        ill = ref_encode(in_rtype, int'(in_aluoper), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm), w);
        if (ill) bad("full: bench generated an illegal op");
        fq.push_back({2'(acc), w});
        acc++;
        need_new = 1'b1;
      end else begin
        need_new = 1'b0;
      end
      @(negedge clock);
    end
    f_valid = 1'b0;
    check("full accepts", 32'(acc), 32'd4);
    check("full writes", 32'(fwrites), 32'd4);
    check("full done", 32'(f_done), 32'd1);
    check("full busy", 32'(f_busy), 32'd0);
    check("full in_ready", 32'(f_ready), 32'd0);
    check("full count", 32'(f_count), 32'd4);
    check("full error", 32'(f_error), 32'd0);
    check("full drained", 32'(fq.size()), 32'd0);

    // reset mid-load
    do_start();
    send_rand(1'b0);
    send(1'b1, 4'b0011, 5'd10, 5'd11, 5'd12, 12'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("midreset in_ready", 32'(in_ready), 32'd0);
    check("midreset mem_we", 32'(mem_we), 32'd0);
    check("midreset mem_addr", 32'(mem_addr), 32'd0);
    check("midreset mem_wdata", mem_wdata, 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset error", 32'(error), 32'd0);
    check("midreset count", 32'(count), 32'd0);
    reset = 1'b0;
    check("midreset drained", 32'(exp_q.size()), 32'd0);

    // restart from address 0; a start pulse during LOAD must not restart
    do_start();
    send(1'b1, 4'b1000, 5'd1, 5'd2, 5'd3, 12'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start in LOAD busy", 32'(busy), 32'd1);
    check("start in LOAD count", 32'(count), 32'd1);
    send(1'b0, 4'b1001, 5'd7, 5'd6, 5'd0, 12'hFFF, 1'b1, 1'b0, 32'h0);
    finish_load("restart");

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
